// File: rtl/mem_arbiter.sv
// Multi-channel arbiter onto a single external memory bus with a single outstanding transaction.
// Fixed-priority or round-robin grant selection, wait-state stall and timeout abort.
module mem_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RR_MODE    = 0,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    output logic [NUM_CH-1:0]        ack_o,
    output logic                     err_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     busy_o,
    output logic [ADDR_W-1:0]        addr_o,
    output logic                     re_o,
    output logic                     we_o,
    inout  wire  [DATA_W-1:0]        data_io,
    input  logic                     needWait_i
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_M1 = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]        state_reg;
    logic [PTR_W-1:0]  grant_reg;
    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic [PTR_W-1:0]  sel_next;
    logic              found_next;
    logic [NUM_CH-1:0] cand_next;
    logic              timeout_next;

    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [DATA_W-1:0] ch_wdata [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_addr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
            assign ch_wdata[gi] = wdata_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A channel being acked this cycle still holds req_i; masking it avoids a double grant.
    assign cand_next = req_i & ~ack_o;

    always_comb begin
        int idx;
        found_next = 1'b0;
        sel_next   = '0;
        idx        = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (RR_MODE != 0) ? (int'(rr_ptr_reg) + i) % NUM_CH : i;
            if (!found_next && cand_next[idx]) begin
                found_next = 1'b1;
                sel_next   = PTR_W'(idx);
            end
        end
    end

    assign timeout_next = (WAIT_LIMIT != 0) && (wait_cnt_reg == LIMIT_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            wdata_reg    <= '0;
            wait_cnt_reg <= '0;
            ack_o        <= '0;
            err_o        <= 1'b0;
            rdata_o      <= '0;
            addr_o       <= '0;
            re_o         <= 1'b0;
            we_o         <= 1'b0;
        end else begin
            ack_o <= '0;
            err_o <= 1'b0;
            if (state_reg == IDLE) begin
                if (found_next) begin
                    grant_reg    <= sel_next;
                    addr_o       <= ch_addr[sel_next];
                    wdata_reg    <= ch_wdata[sel_next];
                    re_o         <= ~we_i[sel_next];
                    we_o         <= we_i[sel_next];
                    wait_cnt_reg <= '0;
                    state_reg    <= ACCESS;
                end
            end else if (!needWait_i || timeout_next) begin
                // Normal completion or timeout abort; read data is only taken on success.
                if (!needWait_i && re_o) begin
                    rdata_o <= data_io;
                end
                ack_o[grant_reg] <= 1'b1;
                err_o            <= needWait_i;
                re_o             <= 1'b0;
                we_o             <= 1'b0;
                state_reg        <= IDLE;
                rr_ptr_reg       <= (grant_reg == LAST_CH) ? '0 : grant_reg + 1'b1;
            end else if (wait_cnt_reg != '1) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
        end
    end

    assign busy_o  = (state_reg == ACCESS);
    assign data_io = we_o ? wdata_reg : 'z;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a fixed-priority 2-channel instance and a round-robin 3-channel instance.
module tb_mem_arbiter;

    typedef struct {
        int          ch;
        bit          err;
        logic [15:0] rd;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic clk = 1'b0;
    logic rst;

    // Instance A: fixed priority, 2 channels, WAIT_LIMIT=4
    logic [1:0]  req_a, we_a, ack_a;
    logic [31:0] addr_in_a, wdata_in_a;
    logic        err_a, busy_a, re_a, wstb_a, nw_a;
    logic [15:0] rdata_a, addr_a;
    wire  [15:0] bus_a;

    // Instance B: round robin, 3 channels
    logic [2:0]  req_b, we_b, ack_b;
    logic [47:0] addr_in_b, wdata_in_b;
    logic        err_b, busy_b, re_b, wstb_b, nw_b;
    logic [15:0] rdata_b, addr_b;
    wire  [15:0] bus_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] bus_rd(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'h0020: return 16'h1234;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    assign bus_a = wstb_a ? 16'hzzzz : bus_rd(addr_a);
    assign bus_b = wstb_b ? 16'hzzzz : bus_rd(addr_b);

    mem_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .RR_MODE(0), .WAIT_LIMIT(4)) dut_a (
        .clk(clk), .rst(rst), .req_i(req_a), .we_i(we_a), .addr_i(addr_in_a),
        .wdata_i(wdata_in_a), .ack_o(ack_a), .err_o(err_a), .rdata_o(rdata_a),
        .busy_o(busy_a), .addr_o(addr_a), .re_o(re_a), .we_o(wstb_a),
        .data_io(bus_a), .needWait_i(nw_a)
    );

    mem_arbiter #(.NUM_CH(3), .ADDR_W(16), .DATA_W(16), .RR_MODE(1), .WAIT_LIMIT(255)) dut_b (
        .clk(clk), .rst(rst), .req_i(req_b), .we_i(we_b), .addr_i(addr_in_b),
        .wdata_i(wdata_in_b), .ack_o(ack_b), .err_o(err_b), .rdata_o(rdata_b),
        .busy_o(busy_b), .addr_o(addr_b), .re_o(re_b), .we_o(wstb_b),
        .data_io(bus_b), .needWait_i(nw_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester behaviour for A: drop req on the edge after seeing its ack.
    task automatic drain_a(input int budget);
        int n;
        logic [1:0] seen;
        n = 0;
        while ((req_a != 2'b00 || busy_a) && n < budget) begin
            @(negedge clk);
            seen = ack_a;
            tick();
            req_a = req_a & ~seen;
            n++;
        end
        if (req_a != 2'b00 || busy_a) begin
            total++;
            bad++;
            $display("FAIL a_drain_timeout: req %b busy %b after %0d cycles", req_a, busy_a, n);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ack_a != 2'b00) begin
            $display("cyc %0d A ack %b err %b rdata %h", cyc, ack_a, err_a, rdata_a);
            if (q_a.size() == 0) begin
                check("a_unexpected_ack", 32'(ack_a), 32'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_ack_ch", 32'(ack_a), 32'(1) << e.ch);
                check("a_err", 32'(err_a), 32'(e.err));
                check("a_rdata", 32'(rdata_a), 32'(e.rd));
                check("a_ack_cycle", 32'(cyc), 32'(e.cyc));
                check("a_strobes_off", {30'd0, re_a, wstb_a}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ack_b != 3'b000) begin
            $display("cyc %0d B ack %b err %b rdata %h", cyc, ack_b, err_b, rdata_b);
            if (q_b.size() == 0) begin
                check("b_unexpected_ack", 32'(ack_b), 32'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_ack_ch", 32'(ack_b), 32'(1) << e.ch);
                check("b_err", 32'(err_b), 32'(e.err));
                check("b_rdata", 32'(rdata_b), 32'(e.rd));
                check("b_ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int t0;
        rst = 1'b1;
        req_a = '0; we_a = '0; addr_in_a = '0; wdata_in_a = '0; nw_a = 1'b0;
        req_b = '0; we_b = '0; addr_in_b = '0; wdata_in_b = '0; nw_b = 1'b0;
        repeat (3) tick();

        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_re_a", 32'(re_a), 32'd0);
        check("rst_we_a", 32'(wstb_a), 32'd0);
        check("rst_ack_a", 32'(ack_a), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_rdata_a", 32'(rdata_a), 32'd0);
        check("rst_addr_a", 32'(addr_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;
        tick();

        // Fixed priority: both channels request together, ch0 first.
        t0 = cyc;
        addr_in_a = {16'h0020, 16'h0010};
        we_a = 2'b00;
        req_a = 2'b11;
        q_a.push_back('{0, 1'b0, 16'hBEEF, t0 + 2});
        q_a.push_back('{1, 1'b0, 16'h1234, t0 + 4});
        drain_a(20);

        // Ch1 write with three stall cycles.
        t0 = cyc;
        we_a = 2'b10;
        addr_in_a[31:16] = 16'h8000;
        wdata_in_a[31:16] = 16'h00FF;
        nw_a = 1'b1;
        req_a = 2'b10;
        q_a.push_back('{1, 1'b0, 16'h1234, t0 + 5});
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("wr_we_o", 32'(wstb_a), 32'd1);
            check("wr_re_o", 32'(re_a), 32'd0);
            check("wr_addr_o", 32'(addr_a), 32'h8000);
            check("wr_data_io", 32'(bus_a), 32'h00FF);
            if (i == 3) begin
                tick();
                nw_a = 1'b0;
            end
        end
        drain_a(20);
        we_a = 2'b00;

        // Timeout on a read: error ack after 4 wait cycles, rdata untouched.
        t0 = cyc;
        addr_in_a[15:0] = 16'h0030;
        nw_a = 1'b1;
        req_a = 2'b01;
        q_a.push_back('{0, 1'b1, 16'h1234, t0 + 5});
        drain_a(20);
        nw_a = 1'b0;

        t0 = cyc;
        addr_in_a[15:0] = 16'h0010;
        req_a = 2'b01;
        q_a.push_back('{0, 1'b0, 16'hBEEF, t0 + 2});
        drain_a(20);

        // Ch0 drops req one cycle after grant: ack still issues, no regrant.
        t0 = cyc;
        addr_in_a[15:0] = 16'h0040;
        req_a = 2'b01;
        q_a.push_back('{0, 1'b0, 16'h5A1A, t0 + 2});
        tick();
        req_a = 2'b00;
        repeat (3) tick();
        check("drop_busy_a", 32'(busy_a), 32'd0);
        check("drop_queue_a", 32'(q_a.size()), 32'd0);

        // Round robin with all three held high: 0,1,2,0.
        t0 = cyc;
        addr_in_b = {16'h0060, 16'h0020, 16'h0010};
        req_b = 3'b111;
        q_b.push_back('{0, 1'b0, 16'hBEEF, t0 + 2});
        q_b.push_back('{1, 1'b0, 16'h1234, t0 + 4});
        q_b.push_back('{2, 1'b0, 16'h5A3A, t0 + 6});
        q_b.push_back('{0, 1'b0, 16'hBEEF, t0 + 8});
        repeat (7) tick();
        req_b = 3'b000;
        repeat (4) tick();
        check("rr_busy_b", 32'(busy_b), 32'd0);
        check("rr_queue_b", 32'(q_b.size()), 32'd0);

        // Reset during a stalled access: strobes drop, no ack.
        t0 = cyc;
        addr_in_a[31:16] = 16'h0050;
        nw_a = 1'b1;
        req_a = 2'b10;
        tick();
        tick();
        check("pre_rst_busy_a", 32'(busy_a), 32'd1);
        check("pre_rst_re_a", 32'(re_a), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_re_a", 32'(re_a), 32'd0);
        check("mid_rst_we_a", 32'(wstb_a), 32'd0);
        check("mid_rst_busy_a", 32'(busy_a), 32'd0);
        check("mid_rst_ack_a", 32'(ack_a), 32'd0);
        req_a = 2'b00;
        nw_a = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_no_ack_queue_a", 32'(q_a.size()), 32'd0);
        check("rst_idle_a", 32'(busy_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
